// File: rtl/wb_cmd_master_pkg.sv
// Shared types and constants for the Wishbone command master.
package wb_cmd_master_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RSP = 2'd2} state_e;

  localparam logic [31:0] WB_DEBUG_BASE      = 32'h300F_FFF8;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;
endpackage

// File: rtl/wb_cmd_timeout.sv
// Saturating REQ-cycle counter; expired_o flags the last allowed wait cycle.
module wb_cmd_timeout
  import wb_cmd_master_pkg::*;
#(
  parameter int unsigned MAX_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                        cnt_d = '0;
    else if (en_i && cnt_q != MAX_C)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Fires while the count is about to reach MAX, so REQ lasts exactly MAX cycles.
  assign expired_o = en_i && (cnt_q >= MAX_C - 1'b1);
endmodule

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone classic initiator driven by a valid/ready command port.
// Optional ack timeout enabled by defining WB_CMD_MASTER_TIMEOUT_EN.
module wb_cmd_master
  import wb_cmd_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter logic [31:0] DEF_RDATA      = 32'h0000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [3:0]  cmd_sel_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic        busy_o
);
  state_e      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_dat_q, rsp_dat_d;
  logic        busy_q, busy_d;
  logic        timeout_hit;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
  logic rsp_err_q, rsp_err_d;

  wb_cmd_timeout #(.MAX_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .clr_i     (state_q == IDLE && cmd_valid_i),
    .en_i      (state_q == REQ && !wbm_ack_i),
    .expired_o (timeout_hit)
  );
  assign rsp_err_o = rsp_err_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_err_o   = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    busy_d      = busy_q;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    rsp_err_d   = rsp_err_q;
`endif
    case (state_q)
      IDLE: if (cmd_valid_i) begin
        state_d     = REQ;
        cmd_ready_d = 1'b0;
        cyc_d       = 1'b1;
        busy_d      = 1'b1;
        we_d        = cmd_we_i;
        sel_d       = cmd_sel_i;
        adr_d       = cmd_adr_i;
        dat_d       = cmd_dat_i;
      end
      // Ack takes priority over a simultaneous timeout.
      REQ: if (wbm_ack_i || timeout_hit) begin
        state_d     = RSP;
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_dat_d   = we_q ? 32'h0 : (wbm_ack_i ? wbm_dat_i : DEF_RDATA);
`ifdef WB_CMD_MASTER_TIMEOUT_EN
        rsp_err_d   = !wbm_ack_i;
`endif
      end
      RSP: if (rsp_ready_i) begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      busy_q      <= 1'b0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      busy_q      <= busy_d;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign busy_o      = busy_q;
endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master; the timeout scenario follows WB_CMD_MASTER_TIMEOUT_EN.
module tb_wb_cmd_master;
  localparam logic [31:0] DEFR = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_we = 1'b0;
  logic [3:0]  cmd_sel = '0;
  logic [31:0] cmd_adr = '0, cmd_dat = '0;
  logic        rsp_ready = 1'b0, ack = 1'b0;
  logic [31:0] wdat_i = '0;
  logic        cmd_ready, rsp_valid, rsp_err, cyc, stb, we, busy;
  logic [31:0] rsp_dat, adr, dat_o;
  logic [3:0]  sel;
  int tests = 0, fails = 0;

  wb_cmd_master #(.TIMEOUT_CYCLES(8), .DEF_RDATA(DEFR)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_sel_i(cmd_sel), .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_ack_i(ack), .wbm_dat_i(wdat_i), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    tests++; if ({cmd_ready, cyc, stb, busy, rsp_valid, rsp_err} !== 6'b100000) begin
      $display("FAIL reset_ctrl: got %b exp 100000", {cmd_ready, cyc, stb, busy, rsp_valid, rsp_err}); fails++; end
    tests++; if ({rsp_dat, adr, dat_o, sel, we} !== 101'h0) begin
      $display("FAIL reset_data: got rsp_dat=%h adr=%h dat=%h sel=%h we=%b", rsp_dat, adr, dat_o, sel, we); fails++; end
  endtask

  task automatic test_write_zero_wait();
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_sel = 4'hF; cmd_adr = 32'h300F_FFF8; cmd_dat = 32'hA5A5_0001;
    rsp_ready = 1'b1;
    tick(); cmd_valid = 1'b0;
    tests++; if ({cyc, stb, we, cmd_ready, busy, rsp_valid} !== 6'b111010) begin
      $display("FAIL wr_req_ctrl: got %b exp 111010", {cyc, stb, we, cmd_ready, busy, rsp_valid}); fails++; end
    tests++; if ({adr, dat_o, sel} !== {32'h300F_FFF8, 32'hA5A5_0001, 4'hF}) begin
      $display("FAIL wr_req_bus: got adr=%h dat=%h sel=%h", adr, dat_o, sel); fails++; end
    ack = 1'b1; wdat_i = 32'hFFFF_FFFF;
    tick(); ack = 1'b0;
    tests++; if ({cyc, stb, rsp_valid, rsp_err} !== 4'b0010 || rsp_dat !== 32'h0) begin
      $display("FAIL wr_rsp: got cyc=%b stb=%b valid=%b err=%b dat=%h exp 0 0 1 0 00000000", cyc, stb, rsp_valid, rsp_err, rsp_dat); fails++; end
    tick();
    tests++; if ({rsp_valid, cmd_ready, busy, cyc} !== 4'b0100) begin
      $display("FAIL wr_done: got %b exp 0100", {rsp_valid, cmd_ready, busy, cyc}); fails++; end
  endtask

  task automatic test_read_wait();
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 4'h3; cmd_adr = 32'h3000_0004; cmd_dat = 32'h5555_5555;
    rsp_ready = 1'b1; wdat_i = 32'hDEAD_BEEF;
    tick();
    cmd_adr = 32'h1111_1111; cmd_sel = 4'hC;  // later offers must not disturb the held bus fields
    for (int i = 0; i < 6; i++) begin
      tests++; if ({cyc, we, cmd_ready, rsp_valid} !== 4'b1000 || adr !== 32'h3000_0004 || sel !== 4'h3) begin
        $display("FAIL rd_wait%0d: got cyc=%b we=%b rdy=%b valid=%b adr=%h sel=%h", i, cyc, we, cmd_ready, rsp_valid, adr, sel); fails++; end
      if (i == 5) begin ack = 1'b1; wdat_i = 32'h1234_5678; cmd_valid = 1'b0; end
      tick();
    end
    ack = 1'b0;
    tests++; if ({cyc, rsp_valid, rsp_err} !== 3'b010 || rsp_dat !== 32'h1234_5678) begin
      $display("FAIL rd_rsp: got cyc=%b valid=%b err=%b dat=%h exp 0 1 0 12345678", cyc, rsp_valid, rsp_err, rsp_dat); fails++; end
    tick();
    tests++; if ({rsp_valid, cmd_ready, cyc} !== 3'b010) begin
      $display("FAIL rd_done: got %b exp 010", {rsp_valid, cmd_ready, cyc}); fails++; end
  endtask

  task automatic test_rsp_hold();
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_adr = 32'h3000_0010; rsp_ready = 1'b0;
    tick(); cmd_valid = 1'b0;
    ack = 1'b1; wdat_i = 32'hCAFE_F00D;
    tick(); ack = 1'b0; wdat_i = 32'h0;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0020; cmd_dat = 32'h0000_00AA;
    for (int i = 0; i < 10; i++) begin
      tests++; if ({rsp_valid, cmd_ready, cyc} !== 3'b100 || rsp_dat !== 32'hCAFE_F00D) begin
        $display("FAIL hold%0d: got valid=%b rdy=%b cyc=%b dat=%h", i, rsp_valid, cmd_ready, cyc, rsp_dat); fails++; end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    tests++; if ({rsp_valid, cmd_ready, cyc} !== 3'b010) begin
      $display("FAIL hold_release: got %b exp 010", {rsp_valid, cmd_ready, cyc}); fails++; end
    tick(); cmd_valid = 1'b0;
    tests++; if (cyc !== 1'b1 || adr !== 32'h3000_0020 || we !== 1'b1) begin
      $display("FAIL hold_next: got cyc=%b adr=%h we=%b", cyc, adr, we); fails++; end
    ack = 1'b1; tick(); ack = 1'b0; tick();
  endtask

  task automatic test_timeout();
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0030; rsp_ready = 1'b0;
    tick(); cmd_valid = 1'b0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      tests++; if (cyc !== 1'b1 || rsp_valid !== 1'b0) begin
        $display("FAIL to_req%0d: got cyc=%b valid=%b exp 1 0", i, cyc, rsp_valid); fails++; end
      tick();
    end
    tests++; if ({cyc, rsp_valid, rsp_err} !== 3'b011 || rsp_dat !== DEFR) begin
      $display("FAIL to_rsp: got cyc=%b valid=%b err=%b dat=%h exp 0 1 1 %h", cyc, rsp_valid, rsp_err, rsp_dat, DEFR); fails++; end
`else
    for (int i = 0; i < 20; i++) begin
      tests++; if (cyc !== 1'b1 || rsp_valid !== 1'b0) begin
        $display("FAIL wait_req%0d: got cyc=%b valid=%b exp 1 0", i, cyc, rsp_valid); fails++; end
      tick();
    end
    ack = 1'b1; wdat_i = 32'h0BAD_CAFE; tick(); ack = 1'b0;
    tests++; if ({cyc, rsp_valid, rsp_err} !== 3'b010 || rsp_dat !== 32'h0BAD_CAFE) begin
      $display("FAIL wait_rsp: got cyc=%b valid=%b err=%b dat=%h", cyc, rsp_valid, rsp_err, rsp_dat); fails++; end
`endif
    ack = 1'b1; rsp_ready = 1'b1;
    tick(); tick();
    tests++; if ({cyc, rsp_valid, cmd_ready} !== 3'b001) begin
      $display("FAIL stray_ack: got %b exp 001", {cyc, rsp_valid, cmd_ready}); fails++; end
    ack = 1'b0;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_dat = 32'h7777_0000;
    tick(); cmd_valid = 1'b0; ack = 1'b1; tick(); ack = 1'b0;
    tests++; if ({rsp_valid, rsp_err} !== 2'b10 || rsp_dat !== 32'h0) begin
      $display("FAIL after_to: got valid=%b err=%b dat=%h exp 1 0 00000000", rsp_valid, rsp_err, rsp_dat); fails++; end
    tick();
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0040; rsp_ready = 1'b1;
    tick(); cmd_valid = 1'b0; tick();
    rst = 1'b1; tick(); rst = 1'b0;
    tests++; if ({cyc, stb, busy, cmd_ready, rsp_valid} !== 5'b00010) begin
      $display("FAIL rst_mid: got %b exp 00010", {cyc, stb, busy, cmd_ready, rsp_valid}); fails++; end
    ack = 1'b1; tick(); tick(); ack = 1'b0;
    tests++; if ({cyc, rsp_valid} !== 2'b00) begin
      $display("FAIL rst_no_rsp: got cyc=%b valid=%b exp 0 0", cyc, rsp_valid); fails++; end
  endtask

  task automatic test_back_to_back();
    int n_acc = 0, n_rsp = 0, n_cyc = 0, overlap = 0;
    int acc_at[2] = '{0, 0};
    logic prev_cyc = 1'b0;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0050; rsp_ready = 1'b1;
    ack = 1'b1; wdat_i = 32'h0BB0_0001;
    for (int i = 0; i < 10; i++) begin
      if (cmd_valid && cmd_ready) begin if (n_acc < 2) acc_at[n_acc] = i; n_acc++; end
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        tests++; if (rsp_dat !== 32'h0BB0_0001) begin
          $display("FAIL b2b_dat: got %h exp 0bb00001", rsp_dat); fails++; end
      end
      if (cyc) n_cyc++;
      if (cyc && prev_cyc) overlap++;
      prev_cyc = cyc;
      tick();
      if (n_acc == 2) cmd_valid = 1'b0;
    end
    ack = 1'b0;
    tests++; if (n_acc !== 2 || n_rsp !== 2 || n_cyc !== 2 || overlap !== 0) begin
      $display("FAIL b2b_count: got acc=%0d rsp=%0d cyc=%0d overlap=%0d exp 2 2 2 0", n_acc, n_rsp, n_cyc, overlap); fails++; end
    tests++; if (acc_at[1] - acc_at[0] !== 3) begin
      $display("FAIL b2b_spacing: got %0d exp 3", acc_at[1] - acc_at[0]); fails++; end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_rsp_hold();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
